// File: rtl/layernorm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layernorm_pkg
//  Description : Shared sizes and bank-state encoding for the LayerNorm
//                vector packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package layernorm_pkg;

    localparam int N_ELEM     = 64;
    localparam int ELEM_W     = 16;
    localparam int VEC_W      = N_ELEM * ELEM_W;
    localparam int LANE_IDX_W = 6;
    localparam int LEN_W      = 7;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/vec_pack_64_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pack_64_if
//  Description : Element-stream input and packed-vector output handshakes
//                of the LayerNorm packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vec_pack_64_if;
    import layernorm_pkg::*;

    logic                elem_valid;
    logic                elem_ready;
    logic [ELEM_W-1:0]   elem_data;
    logic                elem_last;
    logic                vec_valid;
    logic                vec_ready;
    logic [VEC_W-1:0]    vec_data;
    logic [LEN_W-1:0]    vec_len;

    // Environment side: produces elements, consumes vectors.
    modport master (
        output elem_valid, elem_data, elem_last, vec_ready,
        input  elem_ready, vec_valid, vec_data, vec_len
    );

    // Packer side.
    modport slave (
        input  elem_valid, elem_data, elem_last, vec_ready,
        output elem_ready, vec_valid, vec_data, vec_len
    );

endinterface
`default_nettype wire

// File: rtl/vec_pack_bank.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pack_bank
//  Description : One vector bank: lane storage, fill counter and
//                EMPTY/FILLING/FULL state.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_pack_bank
    import layernorm_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               wr_en_i,
    input  wire logic [ELEM_W-1:0]  wr_data_i,
    input  wire logic               wr_last_i,
    input  wire logic               clr_i,
    output bank_state_e             state_o,
    output logic [LEN_W-1:0]        len_o,
    output logic [VEC_W-1:0]        data_o
);

    logic [VEC_W-1:0]      data_q, data_d;
    logic [LEN_W-1:0]      len_q, len_d;
    bank_state_e           state_q, state_d;
    logic [LANE_IDX_W-1:0] w_lane;

    assign w_lane = len_q[LANE_IDX_W-1:0];

    // Clearing on drain is what makes unused lanes of a short vector read zero.
    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        state_d = state_q;
        if (clr_i) begin
            data_d  = '0;
            len_d   = '0;
            state_d = EMPTY;
        end else if (wr_en_i) begin
            data_d[int'(w_lane)*ELEM_W +: ELEM_W] = wr_data_i;
            len_d   = len_q + LEN_W'(1);
            state_d = ((len_q == LEN_W'(N_ELEM-1)) || wr_last_i) ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            len_q   <= '0;
            state_q <= EMPTY;
        end else begin
            data_q  <= data_d;
            len_q   <= len_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign len_o   = len_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/vec_pack_64.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pack_64
//  Description : Double-banked serial-to-parallel packer, Q8.8 elements into
//                64-lane vectors for the LayerNorm statistics stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_pack_64
    import layernorm_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    vec_pack_64_if.slave  bus
);

    bank_state_e      w_state [2];
    logic [LEN_W-1:0] w_len   [2];
    logic [VEC_W-1:0] w_data  [2];

    logic wr_sel_q, wr_sel_d;
    logic rd_sel_q, rd_sel_d;
    logic w_elem_ready, w_accept, w_closes;
    logic w_vec_valid, w_pop;

    // Both handshake outputs decode registered bank state only.
    assign w_elem_ready = (w_state[wr_sel_q] != FULL);
    assign w_vec_valid  = (w_state[rd_sel_q] == FULL);
    assign w_accept     = bus.elem_valid & w_elem_ready;
    assign w_pop        = w_vec_valid & bus.vec_ready;
    assign w_closes     = w_accept &&
                          ((w_len[wr_sel_q] == LEN_W'(N_ELEM-1)) || bus.elem_last);

    assign wr_sel_d = wr_sel_q ^ w_closes;
    assign rd_sel_d = rd_sel_q ^ w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        vec_pack_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (w_accept && (wr_sel_q == 1'(b))),
            .wr_data_i (bus.elem_data),
            .wr_last_i (bus.elem_last),
            .clr_i     (w_pop && (rd_sel_q == 1'(b))),
            .state_o   (w_state[b]),
            .len_o     (w_len[b]),
            .data_o    (w_data[b])
        );
    end

    assign bus.elem_ready = w_elem_ready;
    assign bus.vec_valid  = w_vec_valid;
    assign bus.vec_data   = w_data[rd_sel_q];
    assign bus.vec_len    = w_len[rd_sel_q];

endmodule
`default_nettype wire

// File: tb/tb_vec_pack_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_pack_64
//  Description : Directed self-checking bench for vec_pack_64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_pack_64;
    import layernorm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_pack_64_if bus ();

    vec_pack_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [VEC_W-1:0] data;
        logic [LEN_W-1:0] len;
    } exp_t;

    typedef struct {
        int          n;
        bit          last;
        logic [15:0] base;
        int          exp_len;
    } rec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    int   stalls   = 0;

    task automatic chk(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected vector: lane k = base + k for k < len, remaining lanes zero.
    task automatic push_exp(input logic [15:0] base, input int len);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < len; k++) e.data[k*16 +: 16] = base + 16'(k);
        e.len = 7'(len);
        exp_q.push_back(e);
    endtask

    task automatic send_elem(input logic [15:0] d, input logic last);
        bit acc = 1'b0;
        bus.elem_valid = 1'b1;
        bus.elem_data  = d;
        bus.elem_last  = last;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = (bus.elem_ready === 1'b1);
            @(posedge clk); #1;
            if (!acc) stalls++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: elem_ready %b want 1", bus.elem_ready);
        end
        bus.elem_valid = 1'b0;
        bus.elem_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: every pop must match the oldest expected vector.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.vec_valid === 1'b1 && bus.vec_ready === 1'b1) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got vector len %0d want none", bus.vec_len);
            end else begin
                e = exp_q.pop_front();
                chk("pop_len", bus.vec_len, e.len);
                chk("pop_data", bus.vec_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running want finished");
        $fatal(1, "timeout");
    end

    rec_t             tbl [10];
    logic [VEC_W-1:0] snap;

    initial begin
        tbl[0] = '{64, 1'b0, 16'h0100, 64};
        tbl[1] = '{64, 1'b0, 16'h0140, 64};
        tbl[2] = '{64, 1'b0, 16'h0180, 64};
        tbl[3] = '{64, 1'b0, 16'h01C0, 64};
        tbl[4] = '{10, 1'b1, 16'h0A00, 10};
        tbl[5] = '{64, 1'b0, 16'h0B00, 64};
        tbl[6] = '{64, 1'b1, 16'h2000, 64};
        tbl[7] = '{ 5, 1'b1, 16'h3000,  5};
        tbl[8] = '{ 1, 1'b1, 16'h4000,  1};
        tbl[9] = '{64, 1'b0, 16'hFFC0, 64};

        rst            = 1'b1;
        bus.elem_valid = 1'b0;
        bus.elem_data  = '0;
        bus.elem_last  = 1'b0;
        bus.vec_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_elem_ready", bus.elem_ready, 1);
        chk("rst_vec_valid", bus.vec_valid, 0);
        chk("rst_vec_data", bus.vec_data, 0);
        chk("rst_vec_len", bus.vec_len, 0);
        rst = 1'b0;

        // Basic fill 0x0001..0x0040, latency of vec_valid.
        bus.vec_ready = 1'b1;
        push_exp(16'h0001, 64);
        for (int k = 0; k < 63; k++) send_elem(16'h0001 + 16'(k), 1'b0);
        chk("basic_valid_early", bus.vec_valid, 0);
        send_elem(16'h0040, 1'b0);
        chk("basic_valid_latency", bus.vec_valid, 1);
        chk("basic_len", bus.vec_len, 64);
        chk("basic_lane63", bus.vec_data[VEC_W-1 -: 16], 16'h0040);

        // Table: back-to-back stream, short vector, last on lane 63, tiny vectors.
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 4) begin
                bus.elem_last = 1'b1;   // last without valid must be ignored
                @(posedge clk); #1;
                bus.elem_last = 1'b0;
            end
            push_exp(tbl[i].base, tbl[i].exp_len);
            for (int k = 0; k < tbl[i].n; k++)
                send_elem(tbl[i].base + 16'(k), tbl[i].last && (k == tbl[i].n - 1));
            if (i == 3) chk("b2b_no_stall", stalls, 0);
        end
        chk("table_no_stall", stalls, 0);
        wait_drain();

        // Backpressure with vec_ready low.
        bus.vec_ready = 1'b0;
        stalls = 0;
        push_exp(16'h6000, 64);
        push_exp(16'h6040, 64);
        push_exp(16'h6080, 64);
        for (int k = 0; k < 128; k++) send_elem(16'h6000 + 16'(k), 1'b0);
        chk("bp_no_stall_128", stalls, 0);
        bus.elem_valid = 1'b1;
        bus.elem_data  = 16'h6080;
        bus.elem_last  = 1'b0;
        snap = bus.vec_data;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready_low", bus.elem_ready, 0);
            chk("bp_data_stable", bus.vec_data, snap);
            chk("bp_len_held", bus.vec_len, 64);
        end
        chk("bp_held_lane0", snap[15:0], 16'h6000);
        @(posedge clk); #1;
        bus.vec_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", bus.elem_ready, 0);
        @(posedge clk); #1;
        bus.vec_ready = 1'b0;
        chk("bp_ready_after_pop", bus.elem_ready, 1);
        chk("bp_second_valid", bus.vec_valid, 1);
        chk("bp_second_lane0", bus.vec_data[15:0], 16'h6040);
        send_elem(16'h6080, 1'b0);
        bus.vec_ready = 1'b1;
        for (int k = 129; k < 200; k++) send_elem(16'h6000 + 16'(k), 1'b0);

        // Reset while vector held and next one partially filled.
        bus.vec_ready = 1'b0;
        for (int k = 200; k < 286; k++) send_elem(16'h6000 + 16'(k), 1'b0);
        chk("pre_rst_queue", exp_q.size(), 0);
        chk("pre_rst_valid", bus.vec_valid, 1);
        chk("pre_rst_lane0", bus.vec_data[15:0], 16'h60C0);
        chk("pre_rst_ready", bus.elem_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_elem_ready", bus.elem_ready, 1);
        chk("mid_rst_vec_valid", bus.vec_valid, 0);
        chk("mid_rst_vec_data", bus.vec_data, 0);
        chk("mid_rst_vec_len", bus.vec_len, 0);
        rst = 1'b0;
        bus.vec_ready = 1'b1;
        push_exp(16'h7000, 64);
        for (int k = 0; k < 64; k++) send_elem(16'h7000 + 16'(k), 1'b0);
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("pop_count", n_pops, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
